// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch queue.
package fetch_pkg;

   localparam int FQ_DBITS = 32;

   typedef struct packed {
      logic [FQ_DBITS-1:0] pc;
      logic [FQ_DBITS-1:0] data;
      logic                filled;
   } slot_t;

   // Distance between two wrap-bit pointers of width ptrbits+1.
   function automatic int unsigned ptr_diff(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned ptrbits);
      return (a - b) & ((32'd1 << (ptrbits + 1)) - 32'd1);
   endfunction

endpackage

// File: rtl/fetch_slot_array.sv
// QDEPTH-entry slot storage: pc written on allocate, data on fill,
// filled flag cleared on pop, allocate or flush. Asynchronous reads.
module fetch_slot_array
   import fetch_pkg::*;
#(
   parameter int  DBITS   = FQ_DBITS,
   parameter int  QDEPTH  = 4,
   localparam int PTRBITS = $clog2(QDEPTH)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_flush,
   input  logic               i_alloc_en,
   input  logic [PTRBITS-1:0] i_alloc_idx,
   input  logic [DBITS-1:0]   i_alloc_pc,
   input  logic               i_fill_en,
   input  logic [PTRBITS-1:0] i_fill_idx,
   input  logic [DBITS-1:0]   i_fill_data,
   input  logic               i_pop_en,
   input  logic [PTRBITS-1:0] i_head_idx,
   output logic [DBITS-1:0]   o_head_pc,
   output logic [DBITS-1:0]   o_head_data,
   output logic               o_head_filled,
   output logic [DBITS-1:0]   o_fill_pc
);

   logic [DBITS-1:0]  r_pc   [QDEPTH];
   logic [DBITS-1:0]  r_data [QDEPTH];
   logic [QDEPTH-1:0] r_filled;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < QDEPTH; i++) begin
            r_pc[i]   <= '0;
            r_data[i] <= '0;
         end
         r_filled <= '0;
      end else begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (i_alloc_en && i_alloc_idx == PTRBITS'(i)) r_pc[i] <= i_alloc_pc;
            if (i_fill_en && i_fill_idx == PTRBITS'(i)) r_data[i] <= i_fill_data;
         end
         if (i_flush) begin
            r_filled <= '0;
         end else begin
            for (int i = 0; i < QDEPTH; i++) begin
               if (i_fill_en && i_fill_idx == PTRBITS'(i))
                  r_filled[i] <= 1'b1;
               else if ((i_alloc_en && i_alloc_idx == PTRBITS'(i)) ||
                        (i_pop_en && i_head_idx == PTRBITS'(i)))
                  r_filled[i] <= 1'b0;
            end
         end
      end
   end

   assign o_head_pc     = r_pc[i_head_idx];
   assign o_head_data   = r_data[i_head_idx];
   assign o_head_filled = r_filled[i_head_idx];
   assign o_fill_pc     = r_pc[i_fill_idx];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues in-order fetches, buffers tagged words, drops
// stale responses after a redirect. FETCH_BYPASS_EN adds a zero-latency response path.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int  DBITS   = FQ_DBITS,
   parameter int  QDEPTH  = 4,
   localparam int PTRBITS = $clog2(QDEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [DBITS-1:0] i_pcin,
   output logic             o_stall,
   input  logic             i_flush,
   output logic             o_imem_req,
   output logic [DBITS-1:0] o_imem_addr,
   input  logic             i_imem_gnt,
   input  logic             i_imem_rvalid,
   input  logic [DBITS-1:0] i_imem_rdata,
   output logic             o_inst_valid,
   output logic [DBITS-1:0] o_inst,
   output logic [DBITS-1:0] o_inst_pc,
   input  logic             i_inst_ready
);

   localparam int             PW      = PTRBITS + 1;
   localparam logic [PTRBITS:0] PTR_ONE = PW'(1);
   localparam logic [PTRBITS:0] QD_CNT  = PW'(QDEPTH);

   logic [PTRBITS:0] r_head, r_fill, r_tail, r_drop;
   logic [PTRBITS:0] w_alloc_cnt, w_pend_cnt, w_occ, w_drop_sum, w_drop_flush;
   logic             w_req, w_issue, w_rsp_ok, w_byp, w_byp_pop, w_pop, w_fill_we;
   logic             w_head_filled;
   logic [DBITS-1:0] w_head_pc, w_head_data, w_fill_pc;

   assign w_alloc_cnt = PW'(ptr_diff(32'(r_tail), 32'(r_head), PTRBITS));
   assign w_pend_cnt  = PW'(ptr_diff(32'(r_tail), 32'(r_fill), PTRBITS));
   // alloc+drop never exceeds QDEPTH, so the sum fits the pointer width.
   assign w_occ       = w_alloc_cnt + r_drop;

   assign w_req     = i_rst_n && !i_flush && (w_occ < QD_CNT);
   assign w_issue   = w_req && i_imem_gnt;
   assign w_rsp_ok  = i_imem_rvalid && (r_drop == '0) && (w_pend_cnt != '0) && !i_flush;

`ifdef FETCH_BYPASS_EN
   assign w_byp     = w_rsp_ok && (r_head == r_fill);
`else
   assign w_byp     = 1'b0;
`endif

   assign o_inst_valid = w_byp || ((w_alloc_cnt != '0) && w_head_filled);
   assign o_inst       = w_byp ? i_imem_rdata : w_head_data;
   assign o_inst_pc    = w_byp ? w_fill_pc : w_head_pc;

   assign w_pop     = o_inst_valid && i_inst_ready && !i_flush;
   assign w_byp_pop = w_byp && i_inst_ready;
   assign w_fill_we = w_rsp_ok && !w_byp_pop;

   assign o_imem_req  = w_req;
   assign o_imem_addr = i_pcin;
   assign o_stall     = !w_issue;

   // A response in the flush cycle is the oldest outstanding one and is absorbed here.
   assign w_drop_sum   = r_drop + w_pend_cnt;
   assign w_drop_flush = (i_imem_rvalid && w_drop_sum != '0) ? w_drop_sum - PTR_ONE : w_drop_sum;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_head <= '0;
         r_fill <= '0;
         r_tail <= '0;
         r_drop <= '0;
      end else if (i_flush) begin
         r_head <= '0;
         r_fill <= '0;
         r_tail <= '0;
         r_drop <= w_drop_flush;
      end else begin
         if (w_issue) r_tail <= r_tail + PTR_ONE;
         if (w_rsp_ok) r_fill <= r_fill + PTR_ONE;
         if (w_pop) r_head <= r_head + PTR_ONE;
         if (i_imem_rvalid && r_drop != '0) r_drop <= r_drop - PTR_ONE;
      end
   end

   fetch_slot_array #(
      .DBITS  (DBITS),
      .QDEPTH (QDEPTH)
   ) u_slots (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_flush       (i_flush),
      .i_alloc_en    (w_issue),
      .i_alloc_idx   (r_tail[PTRBITS-1:0]),
      .i_alloc_pc    (i_pcin),
      .i_fill_en     (w_fill_we),
      .i_fill_idx    (r_fill[PTRBITS-1:0]),
      .i_fill_data   (i_imem_rdata),
      .i_pop_en      (w_pop),
      .i_head_idx    (r_head[PTRBITS-1:0]),
      .o_head_pc     (w_head_pc),
      .o_head_data   (w_head_data),
      .o_head_filled (w_head_filled),
      .o_fill_pc     (w_fill_pc)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-level reference model plus directed scenarios.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int QD = 4;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int LAT_OFF = BYP ? 1 : 2;

   logic        clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [31:0] i_pcin = '0;
   logic        o_stall;
   logic        i_flush = 1'b0;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt = 1'b0;
   logic        i_imem_rvalid = 1'b0;
   logic [31:0] i_imem_rdata = '0;
   logic        o_inst_valid;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        i_inst_ready = 1'b0;

   fetch_queue dut (
      .i_clk         (clk),
      .i_rst_n       (i_rst_n),
      .i_pcin        (i_pcin),
      .o_stall       (o_stall),
      .i_flush       (i_flush),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .o_inst_valid  (o_inst_valid),
      .o_inst        (o_inst),
      .o_inst_pc     (o_inst_pc),
      .i_inst_ready  (i_inst_ready)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mdata(input logic [31:0] addr);
      if (addr == 32'h300) return 32'hDEADBEEF;
      return {addr[15:0], ~addr[15:0]};
   endfunction

   // ---------------- reference model ----------------
   slot_t       mq[$];
   slot_t       m_tmp;
   int          m_drop = 0;
   int          m_nf, m_pend;
   logic        e_req, e_valid, e_byp;
   logic [31:0] e_inst, e_pc;

   always @(negedge clk) begin
      if (!i_rst_n) begin
         chk("rst_inst_valid", 32'(o_inst_valid), 32'd0);
         chk("rst_imem_req", 32'(o_imem_req), 32'd0);
         chk("rst_stall", 32'(o_stall), 32'd1);
         chk("rst_inst", o_inst, 32'd0);
         chk("rst_inst_pc", o_inst_pc, 32'd0);
         mq.delete();
         m_drop = 0;
      end else begin
         m_nf = 0;
         foreach (mq[i]) if (mq[i].filled) m_nf++;
         m_pend = mq.size() - m_nf;
         e_req  = !i_flush && (mq.size() + m_drop < QD);
         e_byp  = BYP && (m_nf == 0) && i_imem_rvalid && (m_drop == 0) && (m_pend > 0) && !i_flush;
         if (e_byp) begin
            e_valid = 1'b1;
            e_inst  = i_imem_rdata;
            e_pc    = mq[0].pc;
         end else begin
            e_valid = (mq.size() > 0) && mq[0].filled;
            e_inst  = e_valid ? mq[0].data : 32'd0;
            e_pc    = e_valid ? mq[0].pc : 32'd0;
         end
         chk("imem_req", 32'(o_imem_req), 32'(e_req));
         chk("stall", 32'(o_stall), 32'(!(e_req && i_imem_gnt)));
         chk("imem_addr", o_imem_addr, i_pcin);
         chk("inst_valid", 32'(o_inst_valid), 32'(e_valid));
         if (e_valid) begin
            chk("inst", o_inst, e_inst);
            chk("inst_pc", o_inst_pc, e_pc);
         end
         if (i_flush) begin
            if (i_imem_rvalid && m_drop + m_pend == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL protocol_rsp: response with nothing outstanding (t=%0t)", $time);
            end
            m_drop = m_drop + m_pend - ((i_imem_rvalid && m_drop + m_pend > 0) ? 1 : 0);
            mq.delete();
         end else begin
            if (i_imem_rvalid) begin
               if (m_drop > 0) m_drop--;
               else if (m_pend == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL protocol_rsp: response with nothing outstanding (t=%0t)", $time);
               end else if (!(e_byp && i_inst_ready)) begin
                  m_tmp        = mq[m_nf];
                  m_tmp.data   = i_imem_rdata;
                  m_tmp.filled = 1'b1;
                  mq[m_nf]     = m_tmp;
               end
            end
            if (e_valid && i_inst_ready) void'(mq.pop_front());
            if (e_req && i_imem_gnt) begin
               m_tmp = '{pc: i_pcin, data: 32'd0, filled: 1'b0};
               mq.push_back(m_tmp);
            end
         end
      end
   end

   // ---------------- environment: PC stage + memory ----------------
   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       memq[$];
   mreq_t       m_req;
   int          cyc = 0;
   int          lat = 1;
   int          acc_cnt = 0;
   logic        acc = 1'b0;
   logic [31:0] flush_tgt = '0;

   task automatic step_begin();
      @(negedge clk);
      acc = o_imem_req && i_imem_gnt;
      if (acc) begin
         m_req.addr = o_imem_addr;
         m_req.due  = cyc + lat;
         memq.push_back(m_req);
         acc_cnt++;
      end
   endtask

   task automatic step_end();
      @(posedge clk);
      #1;
      cyc++;
      if (i_flush) i_pcin = flush_tgt;
      else if (acc) i_pcin = i_pcin + 32'd4;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         i_imem_rvalid = 1'b1;
         i_imem_rdata  = mdata(memq[0].addr);
         void'(memq.pop_front());
      end else begin
         i_imem_rvalid = 1'b0;
         i_imem_rdata  = '0;
      end
   endtask

   task automatic step();
      step_begin();
      step_end();
   endtask

   task automatic do_reset(input logic [31:0] pc0);
      i_rst_n       = 1'b0;
      i_imem_gnt    = 1'b0;
      i_inst_ready  = 1'b0;
      i_flush       = 1'b0;
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = '0;
      memq.delete();
      repeat (2) step();
      i_imem_rvalid = 1'b0;
      i_rst_n       = 1'b1;
      i_pcin        = pc0;
   endtask

   task automatic wait_valid(input int maxc, output logic got);
      got = 1'b0;
      for (int i = 0; i < maxc && !got; i++) begin
         step_begin();
         if (o_inst_valid) got = 1'b1;
         else step_end();
      end
   endtask

   logic got;

   initial begin
      // streaming, latency 1
      do_reset(32'h60);
      lat = 1; i_imem_gnt = 1'b1; i_inst_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step_begin();
         if (k < 3) chk("t1_addr", o_imem_addr, 32'h60 + 32'(4 * k));
         chk("t1_stall", 32'(o_stall), 32'd0);
         if (k >= LAT_OFF && k < LAT_OFF + 3) begin
            chk("t1_valid", 32'(o_inst_valid), 32'd1);
            chk("t1_inst_pc", o_inst_pc, 32'h60 + 32'(4 * (k - LAT_OFF)));
         end
         step_end();
      end

      // fill to capacity with decode blocked
      do_reset(32'h1000);
      lat = 1; i_imem_gnt = 1'b1; i_inst_ready = 1'b0; acc_cnt = 0;
      repeat (8) step();
      chk("t2_accepted", 32'(acc_cnt), 32'd4);
      step_begin();
      chk("t2_full_req", 32'(o_imem_req), 32'd0);
      chk("t2_full_stall", 32'(o_stall), 32'd1);
      step_end();
      i_inst_ready = 1'b1;
      step_begin();
      chk("t2_pop_cycle_req", 32'(o_imem_req), 32'd0);
      step_end();
      i_inst_ready = 1'b0; acc_cnt = 0;
      step_begin();
      chk("t2_refill_req", 32'(o_imem_req), 32'd1);
      chk("t2_refill_addr", o_imem_addr, 32'h1010);
      step_end();
      repeat (2) step();
      chk("t2_refill_count", 32'(acc_cnt), 32'd1);

      // grant withheld
      do_reset(32'h2000);
      lat = 1; i_imem_gnt = 1'b0; i_inst_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step_begin();
         chk("t3_stall", 32'(o_stall), 32'd1);
         chk("t3_addr", o_imem_addr, 32'h2000);
         chk("t3_valid", 32'(o_inst_valid), 32'd0);
         step_end();
      end
      i_imem_gnt = 1'b1;
      step();
      i_imem_gnt = 1'b0;
      wait_valid(10, got);
      chk("t3_got_valid", 32'(got), 32'd1);
      if (got) begin
         chk("t3_inst_pc", o_inst_pc, 32'h2000);
         chk("t3_inst", o_inst, mdata(32'h2000));
         step_end();
      end

      // redirect with three fetches outstanding
      do_reset(32'h100);
      lat = 5; i_imem_gnt = 1'b1; i_inst_ready = 1'b1;
      repeat (3) step();
      i_flush = 1'b1; flush_tgt = 32'h200;
      step_begin();
      chk("t4_flush_req", 32'(o_imem_req), 32'd0);
      chk("t4_flush_stall", 32'(o_stall), 32'd1);
      step_end();
      i_flush = 1'b0;
      wait_valid(30, got);
      chk("t4_got_valid", 32'(got), 32'd1);
      if (got) begin
         chk("t4_first_pc", o_inst_pc, 32'h200);
         chk("t4_first_inst", o_inst, mdata(32'h200));
         step_end();
      end

      // flush coinciding with a response and a ready decode
      do_reset(32'h400);
      lat = 3; i_imem_gnt = 1'b1; i_inst_ready = 1'b0;
      repeat (2) step();
      i_imem_gnt = 1'b0;
      step();
      i_flush = 1'b1; i_inst_ready = 1'b1; flush_tgt = 32'h500;
      step_begin();
      chk("t5_flush_valid", 32'(o_inst_valid), 32'd0);
      step_end();
      i_flush = 1'b0;
      step_begin();
      chk("t5_after_valid", 32'(o_inst_valid), 32'd0);
      step_end();
      i_imem_gnt = 1'b1;
      step_begin();
      chk("t5_empty_valid", 32'(o_inst_valid), 32'd0);
      chk("t5_new_addr", o_imem_addr, 32'h500);
      step_end();
      i_imem_gnt = 1'b0;
      wait_valid(20, got);
      chk("t5_got_valid", 32'(got), 32'd1);
      if (got) begin
         chk("t5_first_pc", o_inst_pc, 32'h500);
         step_end();
      end

      // response latency into an empty queue
      do_reset(32'h300);
      lat = 1; i_imem_gnt = 1'b1; i_inst_ready = 1'b0;
      step();
      i_imem_gnt = 1'b0;
      step_begin();
      chk("t6_same_cycle_valid", 32'(o_inst_valid), 32'(BYP));
      if (BYP) chk("t6_same_cycle_inst", o_inst, 32'hDEADBEEF);
      step_end();
      step_begin();
      chk("t6_next_valid", 32'(o_inst_valid), 32'd1);
      chk("t6_next_inst", o_inst, 32'hDEADBEEF);
      chk("t6_next_pc", o_inst_pc, 32'h300);
      step_end();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
